// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: a head register plus a one-entry skid, with flush and a bubble counter.
// Latency 1 cycle; throughput 1/cycle; in_ready is registered and drops only when the skid fills.
module pipe_stage_elastic #(
    parameter int                 DATA_W   = 48,
    parameter int                 CTRL_W   = 12,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_v_q,    main_v_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_v_q,    skid_v_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q,  in_ready_d;
    logic [CNT_W-1:0]  bubble_q,    bubble_d;

    logic accept;
    logic pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = main_v_q & out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            main_v_d    = 1'b0;
            main_ctrl_d = CTRL_NOP;
            skid_v_d    = 1'b0;
            skid_ctrl_d = CTRL_NOP;
        end else if (!main_v_q) begin
            if (accept) begin
                main_v_d    = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end
        end else if (!skid_v_q) begin
            if (pop && accept) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else if (pop) begin
                // Data is left in place; only ctrl is forced so no side effects leak.
                main_v_d    = 1'b0;
                main_ctrl_d = CTRL_NOP;
            end else if (accept) begin
                skid_v_d    = 1'b1;
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
            end
        end else if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
            skid_ctrl_d = CTRL_NOP;
        end

        in_ready_d = ~skid_v_d;
    end

    always_comb begin
        bubble_d = bubble_q;
        if (out_ready && !main_v_q && bubble_q != CNT_MAX) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v_q    <= 1'b0;
            main_ctrl_q <= CTRL_NOP;
            main_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_ctrl_q <= CTRL_NOP;
            skid_data_q <= '0;
            in_ready_q  <= 1'b0;
            bubble_q    <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_v_q    <= skid_v_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            bubble_q    <= bubble_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_v_q;
    assign out_ctrl   = main_ctrl_q;
    assign out_data   = main_data_q;
    assign occupancy  = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue-based reference model compared every cycle, plus directed literal checks.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 48;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 4;
    localparam int BMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;

    pipe_stage_elastic #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_NOP('0),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of at most two entries.
    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic              m_rdy;
    int                m_bub;
    logic [DATA_W-1:0] m_last;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_rdy  = 1'b0;
            m_bub  = 0;
            m_last = '0;
        end else begin
            logic acc;
            logic pp;
            ent_t e;
            acc = in_valid && m_rdy;
            pp  = (mq.size() > 0) && out_ready;
            if (out_ready && mq.size() == 0 && m_bub < BMAX) m_bub++;
            if (flush) begin
                mq.delete();
            end else begin
                if (pp) void'(mq.pop_front());
                if (acc) begin
                    e.c = in_ctrl;
                    e.d = in_data;
                    mq.push_back(e);
                end
            end
            m_rdy = (mq.size() < 2);
            if (mq.size() > 0) m_last = mq[0].d;
        end
    end

    always @(negedge clk) begin
        check("m_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("m_ctrl", 64'(out_ctrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'd0);
        check("m_data", 64'(out_data), (mq.size() > 0) ? 64'(mq[0].d) : 64'(m_last));
        check("m_occ", 64'(occupancy), 64'(mq.size()));
        check("m_rdy", 64'(in_ready), 64'(m_rdy));
        check("m_bub", 64'(bubble_cnt), 64'(m_bub));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1'b0, '0, '0, 1'b0, 1'b0);

        // Test 1: reset, then stream
        step();
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        rst_n = 1'b1;
        step();
        check("rel_rdy", 64'(in_ready), 64'd1);
        check("rel_valid", 64'(out_valid), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            drv(1'b1, 12'h0A5, 48'(i), 1'b1, 1'b0);
            step();
            check("s1_data", 64'(out_data), 64'(i));
            check("s1_ctrl", 64'(out_ctrl), 64'h0A5);
            check("s1_occ", 64'(occupancy), 64'd1);
        end
        check("s1_bub", 64'(bubble_cnt), 64'd1);
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        check("s1_empty", 64'(out_valid), 64'd0);

        // Test 2: backpressure fill and drain
        drv(1'b1, 12'h0A5, 48'h11, 1'b0, 1'b0);
        step();
        drv(1'b1, 12'h0A5, 48'h22, 1'b0, 1'b0);
        step();
        drv(1'b1, 12'h0A5, 48'h33, 1'b0, 1'b0);
        step();
        check("s2_head", 64'(out_data), 64'h11);
        check("s2_occ", 64'(occupancy), 64'd2);
        check("s2_rdy", 64'(in_ready), 64'd0);
        drv(1'b1, 12'h0A5, 48'h33, 1'b1, 1'b0);
        step();
        check("s2_d22", 64'(out_data), 64'h22);
        check("s2_rdy_up", 64'(in_ready), 64'd1);
        step();
        check("s2_d33", 64'(out_data), 64'h33);
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        step();
        check("s2_drained", 64'(occupancy), 64'd0);

        // Test 3: flush while full with a concurrent accept attempt
        drv(1'b1, 12'h0A5, 48'h44, 1'b0, 1'b0);
        step();
        drv(1'b1, 12'h0A5, 48'h55, 1'b0, 1'b0);
        step();
        check("s3_full", 64'(occupancy), 64'd2);
        drv(1'b1, 12'h0A5, 48'h66, 1'b0, 1'b1);
        step();
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        check("s3_valid", 64'(out_valid), 64'd0);
        check("s3_ctrl", 64'(out_ctrl), 64'd0);
        check("s3_occ", 64'(occupancy), 64'd0);
        check("s3_rdy", 64'(in_ready), 64'd1);
        check("s3_data_kept", 64'(out_data), 64'h44);
        step();
        step();

        // Test 4: simultaneous pop and accept, alternating ctrl
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, (i % 2 == 0) ? 12'h001 : 12'h002, 48'(16'h100 + i), 1'b1, 1'b0);
            step();
            check("s4_ctrl", 64'(out_ctrl), (i % 2 == 0) ? 64'h001 : 64'h002);
            check("s4_occ", 64'(occupancy), 64'd1);
        end
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        step();

        // Test 6: asynchronous reset while full
        drv(1'b1, 12'h0A5, 48'h77, 1'b0, 1'b0);
        step();
        drv(1'b1, 12'h0A5, 48'h88, 1'b0, 1'b0);
        step();
        check("s6_full", 64'(occupancy), 64'd2);
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_valid", 64'(out_valid), 64'd0);
        check("s6_occ", 64'(occupancy), 64'd0);
        check("s6_bub", 64'(bubble_cnt), 64'd0);
        check("s6_rdy", 64'(in_ready), 64'd0);
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("s6_rel_rdy", 64'(in_ready), 64'd1);
        drv(1'b1, 12'h0A5, 48'h99, 1'b1, 1'b0);
        step();
        check("s6_data", 64'(out_data), 64'h99);
        check("s6_occ1", 64'(occupancy), 64'd1);
        drv(1'b0, '0, '0, 1'b0, 1'b0);
        step();

        // Test 5: bubble counter saturation, flush inside the window
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("s5_start", 64'(bubble_cnt), 64'd0);
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("s5_five", 64'(bubble_cnt), 64'd5);
        for (int i = 0; i < 13; i++) step();
        check("s5_sat", 64'(bubble_cnt), 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("s5_hold", 64'(bubble_cnt), 64'd15);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed IF_ID/ID_EX/EX_MEM/MEM_WB latches: one generic pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, a synchronous flush and a bubble-counting perf counter.
- Instantiated between any two pipeline stages.
- Upstream stalls by watching in_ready. Hazard or branch logic kills in-flight instructions with flush.
- Flushed or empty slots present CTRL_NOP on the control field, so write-enable and halt bits can never leak downstream.

Parameters:
- DATA_W, 48: width of datapath payload (operands, immediates, PC).
- CTRL_W, 12: width of control payload (RegWrt, MemWrt, halt, RegSrc, ...).
- CTRL_NOP, 0: control value driven when the stage is empty or flushed.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: asynchronous active-low reset (rst=0 resets immediately, regardless of clk).
- in_valid, in, 1: upstream has a valid instruction.
- in_ready, out, 1: stage can accept; registered.
- in_ctrl, in, CTRL_W: upstream control bundle.
- in_data, in, DATA_W: upstream datapath bundle.
- out_valid, out, 1: head entry valid.
- out_ready, in, 1: downstream accepts the head entry this cycle.
- out_ctrl, out, CTRL_W: head control; CTRL_NOP when out_valid=0.
- out_data, out, DATA_W: head datapath payload; holds its last value when out_valid=0.
- flush, in, 1: synchronous kill of all entries.
- occupancy, out, 2: number of valid entries, 0..2.
- bubble_cnt, out, CNT_W: saturating count of starved cycles.

Behaviour:
- Storage:
  - Head register: main_v, main_ctrl, main_data.
  - Skid register: skid_v, skid_ctrl, skid_data.
  - out_* are driven directly from the head register. There is no combinational path from in_* to out_*.
- Handshakes: accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready is registered: next in_ready = ~(next skid_v).
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid when the stage is empty.
  - Sustained throughput is 1 per cycle while out_ready=1.
- State update on each rising edge (flush=0):
  - Empty (main_v=0): accept loads head.
  - Head only, pop & accept: head replaced by the new input.
  - Head only, pop & no accept: head goes empty.
  - Head only, no pop & accept: input goes to skid; in_ready drops the next cycle.
  - Full (both valid): accept is impossible (in_ready=0).
  - Full, pop: skid moves to head, skid goes empty, in_ready rises the next cycle.
  - Full, no pop: hold everything.
- Ordering is strict FIFO. No entry is ever dropped or duplicated without a flush.
- Flush (synchronous, highest priority):
  - Next edge sets main_v=0 and skid_v=0, and both ctrl registers to CTRL_NOP. Data registers are not cleared.
  - An input accepted in the flush cycle is discarded.
  - A pop in the flush cycle still counts as consumed by downstream.
  - in_ready=1 on the following cycle.
- occupancy = main_v + skid_v, combinational from the registers.
- bubble_cnt:
  - Increments by 1 on each edge where out_ready=1 and out_valid=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush; cleared only by reset.
- Reset (rst=0, asynchronous):
  - out_valid=0, out_ctrl=CTRL_NOP, out_data=0, occupancy=0, bubble_cnt=0, in_ready=0.
  - The skid register is cleared the same way.
  - The first rising edge after rst returns high sets in_ready=1. No input is accepted on that edge.
  - Reset asserted mid-transfer discards all entries immediately.
- Illegal or undefined: in_valid=1 while in_ready=0 is a legal hold. Upstream must keep its payload stable, but the stage does not check this.

Test Plan:
1. Reset and streaming:
   - Stimulus: assert rst=0 for 2 cycles, release, then stream in_data=0x0001..0x0008 with in_ctrl=0x0A5 and out_ready=1.
   - Required response: out_valid=0 and out_ctrl=0 during reset. in_ready=1 one edge after release. Outputs appear in order with 1-cycle latency and no gaps. occupancy stays at 1.
2. Backpressure fill:
   - Stimulus: hold out_ready=0 and present 0x11, 0x22, 0x33.
   - Required response: 0x11 in head, 0x22 in skid, occupancy=2, in_ready=0. 0x33 is held upstream. Raising out_ready drains 0x11, 0x22, 0x33 in order.
3. Flush with both entries full, concurrent with an accept attempt:
   - Stimulus: stage full (as in test 2), then assert flush while in_valid=1.
   - Required response: next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy=0, in_ready=1. The flush-cycle input never appears on the output.
4. Simultaneous pop and accept at occupancy 1:
   - Stimulus: out_ready=1 and in_valid=1 every cycle, with alternating ctrl 0x001/0x002.
   - Required response: occupancy remains 1 and ctrl values emerge in input order.
5. Bubble counter saturation:
   - Stimulus: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles.
   - Required response: bubble_cnt reaches 15 and holds at 15. A flush during this window does not change it.
6. Asynchronous reset mid-drain:
   - Stimulus: occupancy=2, then drop rst between clock edges.
   - Required response: out_valid=0, occupancy=0, bubble_cnt=0 before the next edge. After release, the stage behaves as in test 1.
